// File: rtl/dma_m2m_engine.sv
// Memory-to-memory DMA engine: copies len_i words from src to dst
// over a Wishbone classic master, one read then one write per word.
module dma_m2m_engine #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] src_addr_i,
  input  logic [AW-1:0] dst_addr_i,
  input  logic [15:0]   len_i,
  input  logic          go_i,
  input  logic          ie_i,
  input  logic          done_clr_i,
  output logic          busy_o,
  output logic          done_if_o,
  output logic          err_if_o,
  output logic          irq_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [3:0]    sel_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          err_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e        state_q, state_d;
  logic          gap_q, gap_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          active;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gap_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // gap_q marks the idle bus cycle that follows every completed access
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    if (done_clr_i) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          busy_d = 1'b1;
          gap_d  = 1'b0;
          if (len_i == 16'd0) begin
            state_d = DONE;
          end else begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            cnt_d   = len_i;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (err_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (ack_i) begin
          buf_d   = dat_i;
          gap_d   = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (err_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (ack_i) begin
          src_d   = src_q + AW'(4);
          dst_d   = dst_q + AW'(4);
          cnt_d   = cnt_q - 16'd1;
          gap_d   = 1'b1;
          state_d = (cnt_q == 16'd1) ? DONE : RD;
        end
      end
      DONE: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == RD || state_q == WR) && !gap_q;
    cyc_o  = active;
    stb_o  = active;
    we_o   = active && (state_q == WR);
    sel_o  = active ? 4'hF : 4'h0;
    adr_o  = '0;
    dat_o  = '0;
    if (state_q == RD) adr_o = src_q;
    if (state_q == WR) begin
      adr_o = dst_q;
      dat_o = buf_q;
    end
    busy_o    = busy_q;
    done_if_o = done_q;
    err_if_o  = err_q;
    irq_o     = done_q & ie_i;
  end

endmodule
